// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// RV32 load/store width codes and the round-robin grant identifiers.
package mem_pkg;

   // Arbiter FSM states. D_RD is reserved for a future registered-read
   // variant of the data path. The current sequencing goes straight from
   // IDLE to D_RESP or D_MERGE, so D_RD is never entered.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      F_WAIT  = 3'd1,
      D_RD    = 3'd2,
      D_MERGE = 3'd3,
      D_RESP  = 3'd4,
      D_ERR   = 3'd5
   } state_t;

   // RV32 funct3 width codes for loads and stores.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Identity of the requester that received the most recent grant.
   typedef enum logic {
      GNT_FETCH = 1'b0,
      GNT_DATA  = 1'b1
   } grant_t;

   // Returns 1 for the five funct3 codes that name a real access width.
   function automatic logic f3_known(input logic [2:0] f3);
      logic known;
      case (f3)
         F3_B, F3_H, F3_W, F3_BU, F3_HU: known = 1'b1;
         default:                        known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for sub-word data accesses. Purely combinational.
// Loads: extract the addressed byte or halfword from a RAM word and
// sign- or zero-extend it according to funct3.
// Stores: splice the low byte or halfword of the store data into the old
// RAM word at the addressed lane, which gives the read-modify-write result.
module lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] old_word,
   input  logic [31:0] store_data,
   output logic [31:0] merged,
   output logic [31:0] load_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the RAM word.
   always_comb begin
      byte_sel = 8'h00;
      case (offset)
         2'd0: byte_sel = old_word[7:0];
         2'd1: byte_sel = old_word[15:8];
         2'd2: byte_sel = old_word[23:16];
         2'd3: byte_sel = old_word[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = offset[1] ? old_word[31:16] : old_word[15:0];
   end

   // Extend the selected lane to a full load result.
   always_comb begin
      load_word = 32'h0000_0000;
      case (funct3)
         F3_B:    load_word = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_word = {24'h00_0000, byte_sel};
         F3_H:    load_word = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_word = {16'h0000, half_sel};
         F3_W:    load_word = old_word;
         default: load_word = 32'h0000_0000;
      endcase
   end

   // Replace the addressed lane(s) of the old word with the store data.
   always_comb begin
      merged = old_word;
      case (funct3)
         F3_B:    merged[{offset, 3'b000} +: 8]     = store_data[7:0];
         F3_H:    merged[{offset[1], 4'b0000} +: 16] = store_data[15:0];
         F3_W:    merged = store_data;
         default: merged = old_word;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, word-wide RAM between instruction fetch and
// load/store. Arbitration is round-robin and happens only in IDLE. Sub-word
// stores are performed as read-modify-write. Illegal data accesses are
// answered with d_err and never reach the RAM.
//
// Handshake: a requester raises *_req with stable address/control fields and
// holds them until its one-cycle completion pulse (if_rvalid for fetch,
// d_done for data). That pulse is the only acknowledgement; there is no
// separate ready. The requester may drop the request or present a new one in
// the very next cycle, which is always an IDLE arbitration cycle.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [2:0]    d_funct3,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_done,
   output logic [31:0]   d_rdata,
   output logic          d_err,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

   state_t        state;
   grant_t        last_grant;

   // Data-access fields captured at grant, used by later states.
   logic [AW-1:0] op_idx;
   logic [1:0]    op_off;
   logic [2:0]    op_f3;
   logic          op_we;
   logic [31:0]   op_wdata;

   logic          grant_f;
   logic          grant_d;
   logic [29:0]   d_word;
   logic          d_misalign;
   logic          d_illegal;
   logic          d_oor;
   logic          d_bad;
   logic          d_sub_store;
   logic [31:0]   merged_word;
   logic [31:0]   load_word;

   // Fetch wraps modulo the RAM size, so its high address bits and its
   // byte offset are intentionally ignored.
   logic          unused_ok;
   assign unused_ok = ^{if_addr[31:AW+2], if_addr[1:0]};

   // Round-robin choice: on a tie, the requester not served last time wins.
   always_comb begin
      grant_f = if_req && (!d_req || (last_grant == GNT_DATA));
      grant_d = d_req && !grant_f;
   end

   // Legality of the presented data access, evaluated at grant time.
   always_comb begin
      d_word     = d_addr[31:2];
      d_misalign = 1'b0;
      d_illegal  = 1'b0;
      case (d_funct3)
         F3_B, F3_BU: begin
            d_misalign = 1'b0;
         end
         F3_H, F3_HU: begin
            d_misalign = d_addr[0];
         end
         F3_W: begin
            d_misalign = |d_addr[1:0];
         end
         default: begin
            d_illegal = 1'b1;
         end
      endcase
      d_oor       = (d_word >= 30'(DEPTH));
      d_bad       = d_misalign | d_oor | d_illegal | !f3_known(d_funct3) |
                    (d_we & ((d_funct3 == F3_BU) | (d_funct3 == F3_HU)));
      d_sub_store = d_we && (d_funct3 != F3_W);
   end

   lane_align u_lane_align (
      .funct3     (op_f3),
      .offset     (op_off),
      .old_word   (ram_rdata),
      .store_data (op_wdata),
      .merged     (merged_word),
      .load_word  (load_word)
   );

   // FSM: grant in IDLE, then step through the per-transaction sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GNT_FETCH;
         op_idx     <= '0;
         op_off     <= 2'd0;
         op_f3      <= 3'd0;
         op_we      <= 1'b0;
         op_wdata   <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (grant_f) begin
                  last_grant <= GNT_FETCH;
                  state      <= F_WAIT;
               end else if (grant_d) begin
                  last_grant <= GNT_DATA;
                  op_idx     <= d_addr[AW+1:2];
                  op_off     <= d_addr[1:0];
                  op_f3      <= d_funct3;
                  op_we      <= d_we;
                  op_wdata   <= d_wdata;
                  if (d_bad) begin
                     state <= D_ERR;
                  end else if (d_sub_store) begin
                     state <= D_MERGE;
                  end else begin
                     state <= D_RESP;
                  end
               end
            end
            F_WAIT:  state <= IDLE;
            D_MERGE: state <= D_RESP;
            D_RESP:  state <= IDLE;
            D_ERR:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode. Every output is held at 0 while rst is high, so an
   // abandoned transaction can neither write the RAM nor pulse completion.
   always_comb begin
      if_rvalid = 1'b0;
      if_rdata  = 32'h0000_0000;
      d_done    = 1'b0;
      d_rdata   = 32'h0000_0000;
      d_err     = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = 32'h0000_0000;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (grant_f) begin
                  ram_en   = 1'b1;
                  ram_addr = if_addr[AW+1:2];
               end else if (grant_d && !d_bad) begin
                  ram_en   = 1'b1;
                  ram_addr = d_addr[AW+1:2];
                  if (d_we && !d_sub_store) begin
                     ram_we    = 1'b1;
                     ram_wdata = d_wdata;
                  end
               end
            end
            F_WAIT: begin
               if_rvalid = 1'b1;
               if_rdata  = ram_rdata;
            end
            D_MERGE: begin
               ram_en    = 1'b1;
               ram_we    = 1'b1;
               ram_addr  = op_idx;
               ram_wdata = merged_word;
            end
            D_RESP: begin
               d_done = 1'b1;
               if (!op_we) begin
                  d_rdata = load_word;
               end
            end
            D_ERR: begin
               d_done = 1'b1;
               d_err  = 1'b1;
            end
            default: begin
               d_done = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, word-wide data RAM between the instruction-fetch requester and the load/store requester.
- Sequences sub-word accesses: byte/halfword stores become read-modify-write; loads are sign- or zero-extended by funct3.
- Flags misaligned and out-of-range data accesses without touching RAM.
- Sits between the core pipeline and the RAM array, replacing direct core-to-array wiring.

Parameters:
- DEPTH, 256, RAM size in 32-bit words.
- AW, $clog2(DEPTH), RAM word-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_rvalid
- if_addr  in  32  fetch byte address (bits [1:0] ignored)
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word; 0 when if_rvalid=0
- d_req  in  1  data request; held with stable fields until d_done
- d_we  in  1  1=store, 0=load
- d_funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- d_addr  in  32  data byte address
- d_wdata  in  32  store data; low bits used for b/h
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  32  extended load result; valid with d_done on loads, else 0
- d_err  out  1  with d_done: misaligned, out of range, or illegal funct3
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable (qualified by ram_en)
- ram_addr  out  AW  RAM word index
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM read word; registered, valid the cycle after ram_en and !ram_we

Behaviour:
- States: IDLE, F_WAIT, D_RD, D_MERGE, D_RESP, D_ERR.
- Reset (rst=1 at a clock edge):
  - State returns to IDLE.
  - last_grant becomes FETCH.
  - All outputs are 0 in the following cycle.
  - Any in-flight transaction is abandoned with no done or valid pulse, and no RAM write is issued after reset.
- Arbitration happens only in IDLE:
  - Only one requester active: that requester is granted.
  - Both active: the requester not granted last time wins (round-robin).
  - last_grant updates on every grant.
- Data error check is performed at grant, in IDLE:
  - h/hu with addr[0]=1 is an error.
  - w with addr[1:0]≠0 is an error.
  - addr[31:2] ≥ DEPTH is an error.
  - funct3 ∈ {011, 110, 111} is an error.
  - d_we=1 with funct3 bu or hu is an error.
  - On error: go to D_ERR, with no RAM activity.
- Fetch grant:
  - IDLE cycle drives ram_en=1, ram_we=0, ram_addr=if_addr[AW+1:2], then moves to F_WAIT.
  - F_WAIT: if_rvalid=1, if_rdata=ram_rdata; return to IDLE.
  - Latency from grant cycle to if_rvalid: 1 cycle.
- Data load:
  - IDLE issues the read, then moves to D_RESP.
  - D_RESP: d_done=1; d_rdata = selected lane of ram_rdata using addr[1:0].
  - b and h are sign-extended; bu and hu are zero-extended.
  - Return to IDLE.
- Word store:
  - IDLE drives ram_en=1, ram_we=1, ram_wdata=d_wdata, then moves to D_RESP.
  - D_RESP: d_done=1, d_rdata=0.
- Byte/half store:
  - IDLE issues the read, then moves to D_MERGE.
  - D_MERGE writes ram_rdata with the selected lane(s) replaced by d_wdata[7:0] or d_wdata[15:0] at offset addr[1:0]×8, then moves to D_RESP.
- D_ERR: d_done=1, d_err=1, d_rdata=0; return to IDLE.
- A request arriving while busy waits in IDLE with no loss.
- A requester may re-request in the cycle after its pulse; that cycle is an IDLE arbitration cycle.
- Outputs not named for a state are 0 in that state.
- if_addr out of range: wraps modulo DEPTH (fetch never errors).

Decomposition:
- Shared package mem_pkg holds:
  - state enum;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - grant enum {GNT_FETCH, GNT_DATA}.
- One sub-module, lane_align: combinational; funct3, addr[1:0], old word and store data in; merged store word and extended load word out.
- The FSM and arbiter stay in mem_port_arbiter.

Test Plan:
- Fetch alone: RAM[4]=0x12345678, if_req with if_addr=0x10 → ram_en in cycle 0, if_rvalid with if_rdata=0x12345678 in cycle 1.
- Loads from RAM[1]=0x80FF7F01:
  - lb @0x6 → 0xFFFFFFFF
  - lbu @0x7 → 0x00000080
  - lh @0x6 → 0xFFFF80FF
  - lhu @0x4 → 0x00007F01
  - lw @0x4 → 0x80FF7F01
- sb 0xAB @0x9 onto RAM[2]=0x11223344 → RAM[2]=0x1122AB44; d_done at cycle 2 of the transaction. Then sh 0xBEEF @0xA → RAM[2]=0xBEEFAB44.
- Errors, each giving d_err=1 and d_done 1 cycle after grant with no ram_en:
  - lh @0x3
  - sw @0x2
  - lw @(DEPTH×4)
- Both if_req and d_req held for 10 transactions → grants alternate FETCH, DATA, FETCH, and so on, with no starvation.
- rst asserted in D_MERGE cycle → no RAM write occurs and no d_done pulse; next cycle all outputs are 0, state is IDLE, and a subsequent fetch is granted first.
